stb_ctrl: RTL and testbench
===========================

Name: stb_ctrl

Overview:
Measurement sequencer that owns one strobe-generator instance (frequency-measure / strobe block in measure_unit).
- Per start command it resets the generator, arms detection and waits for a stable, in-range period measurement.
- It then enables strobe output and reports the period plus a status code to the SoC register layer.
- Stop, generator error, timeout or out-of-range period return it to idle with output disabled.

Parameters:
T_CNT_WIDTH, 32, width of period bus (must match generator)
RST_CYCLES, 4, cycles gen_rst_o is held high
RUN_HOLD, 4, cycles gen_run_o is held high (covers generator 2-FF sync + edge detect)
STABLE_CYCLES, 8, consecutive cycles gen_period_i must be unchanged to be accepted
TIMEOUT_CYCLES, 2**24, max cycles from arming to accepted period
TMR_WIDTH, 25, timer width, >= clog2(TIMEOUT_CYCLES)+1
MIN_PERIOD, 16, smallest legal period (> generator zero-hold + margin)
MAX_PERIOD, 2**30, largest legal period

Ports:
clk_i  in  1  clock; also clocks generator
arst_i  in  1  async reset, active-high
start_i  in  1  single-cycle start pulse; ignored unless IDLE
stop_i  in  1  single-cycle stop pulse; honoured in any non-IDLE state
gen_rdy_i  in  1  generator idle flag
gen_err_i  in  1  generator error flag
gen_period_i  in  T_CNT_WIDTH  generator measured period
gen_rst_o  out  1  generator reset (to generator arst_i)
gen_run_o  out  1  generator run_det_i
gen_oe_o  out  1  generator oe_i
busy_o  out  1  high in every state except IDLE
running_o  out  1  high in RUN only
done_o  out  1  one-cycle pulse on every return to IDLE from a non-IDLE state
status_o  out  2  0 OK/STOPPED, 1 TIMEOUT, 2 RANGE, 3 GEN_ERR; held until next start
period_o  out  T_CNT_WIDTH  accepted period; held until next accept

Behaviour:
- Reset: reset arst_i, asynchronous, active-high; clock clk_i. All outputs 0, state IDLE, timer 0.
- All outputs registered.
- FSM:
  - IDLE: start_i -> GEN_RST. Timer loaded RST_CYCLES-1, gen_rst_o=1, status_o cleared to 0.
  - GEN_RST: gen_rst_o=1 while timer counts down. At 0 -> ARM, gen_rst_o=0, gen_run_o=1, timer=RUN_HOLD-1.
  - ARM: gen_run_o=1 while timer counts down. At 0 -> WAIT_BUSY, gen_run_o=0, timeout timer=TIMEOUT_CYCLES-1.
  - WAIT_BUSY: gen_rdy_i==0 -> WAIT_STABLE; stable counter=0, last-sample reg=gen_period_i.
  - WAIT_STABLE: each cycle compare gen_period_i with last sample.
    - Differ: counter=0 and update sample.
    - Equal: counter+1.
    - Counter reaches STABLE_CYCLES-1 with equal sample: range check.
      - MIN_PERIOD<=p<=MAX_PERIOD -> RUN; period_o=p, gen_oe_o=1.
      - Otherwise -> IDLE, status=RANGE.
  - RUN: gen_oe_o=1, running_o=1. Timeout timer inactive.
- Timeout: shared across WAIT_BUSY and WAIT_STABLE. Timer hits 0 before acceptance -> IDLE, status=TIMEOUT.
- gen_err_i sampled high in WAIT_STABLE or RUN -> IDLE, status=GEN_ERR. Ignored in GEN_RST/ARM/WAIT_BUSY (generator clears err on its own).
- stop_i in any non-IDLE state -> IDLE, status=0. gen_oe_o, gen_run_o, gen_rst_o drop in that same transition cycle.
- Priority in one cycle: stop_i > gen_err_i > timeout > range/accept.
- start_i while busy_o=1 is ignored. start_i and stop_i together in IDLE: start wins; stop only applies when non-IDLE.
- Entry to IDLE: done_o pulses exactly one cycle.
- Timer: saturates at 0, never wraps. Stable counter saturates at STABLE_CYCLES-1.
- Period comparisons are unsigned, full T_CNT_WIDTH.
- arst_i mid-operation: immediate IDLE, all outputs 0, no done_o pulse.

Decomposition:
- stb_ctrl_pkg holds:
  - typedef enum logic [2:0] stb_ctrl_state_t: IDLE, GEN_RST, ARM, WAIT_BUSY, WAIT_STABLE, RUN.
  - typedef enum logic [1:0] stb_ctrl_status_t: ST_OK, ST_TIMEOUT, ST_RANGE, ST_GEN_ERR.
- One sub-module, cycle_timer: load/enable/zero-flag down-counter of width TMR_WIDTH. Used for the reset, run-hold and timeout intervals.

Test Plan:
- Model generator yields period 1000, stable after 50 cycles. Start -> gen_rst_o high 4 cycles, then gen_run_o high 4 cycles; RUN reached, period_o=1000, gen_oe_o=1, status_o=0.
- Period toggles 1000/1001 every 5 cycles; TIMEOUT_CYCLES=200 -> exit after 200 cycles from arming, done_o 1 cycle, status_o=1, gen_oe_o=0.
- Stable period 8 (<MIN_PERIOD 16) -> IDLE, status_o=2, period_o unchanged from prior value.
- In RUN assert gen_err_i -> next cycle gen_oe_o=0, status_o=3, done_o pulse. Then start -> status_o reads 0 one cycle after start.
- stop_i and gen_err_i same cycle in RUN -> status_o=0. start_i during WAIT_STABLE -> no effect.
- arst_i pulsed in ARM -> all outputs 0 asynchronously, no done_o. Subsequent start runs full sequence normally.

Source files
------------

// File: rtl/stb_ctrl_pkg.sv
// Shared types for the strobe-generator measurement sequencer.
package stb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN_RST,
    ARM,
    WAIT_BUSY,
    WAIT_STABLE,
    RUN
  } stb_ctrl_state_t;

  typedef enum logic [1:0] {
    ST_OK,
    ST_TIMEOUT,
    ST_RANGE,
    ST_GEN_ERR
  } stb_ctrl_status_t;

endpackage

// File: rtl/stb_ctrl_cycle_timer.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module cycle_timer
  import stb_ctrl_pkg::*;
#(
  parameter int TMR_WIDTH = 25
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 load,
  input  logic [TMR_WIDTH-1:0] load_val,
  input  logic                 en,
  output logic                 zero
);

  logic [TMR_WIDTH-1:0] cnt;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/stb_ctrl.sv
// Sequencer for one strobe generator: reset, arm, wait for a stable in-range
// period, then enable strobe output until stop, error, timeout or range fault.
//
// state       | meaning
// IDLE        | generator parked, waiting for start
// GEN_RST     | generator held in reset for RST_CYCLES
// ARM         | run_det held high for RUN_HOLD cycles
// WAIT_BUSY   | waiting for generator to leave idle (timeout running)
// WAIT_STABLE | waiting for STABLE_CYCLES unchanged samples (timeout running)
// RUN         | period accepted, strobe output enabled
module stb_ctrl
  import stb_ctrl_pkg::*;
#(
  parameter int T_CNT_WIDTH    = 32,
  parameter int RST_CYCLES     = 4,
  parameter int RUN_HOLD       = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 2**24,
  parameter int TMR_WIDTH      = 25,
  parameter int MIN_PERIOD     = 16,
  parameter int MAX_PERIOD     = 2**30
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   gen_rdy_i,
  input  logic                   gen_err_i,
  input  logic [T_CNT_WIDTH-1:0] gen_period_i,
  output logic                   gen_rst_o,
  output logic                   gen_run_o,
  output logic                   gen_oe_o,
  output logic                   busy_o,
  output logic                   running_o,
  output logic                   done_o,
  output logic [1:0]             status_o,
  output logic [T_CNT_WIDTH-1:0] period_o
);

  localparam int SC_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SC_W-1:0]        SC_MAX = SC_W'(STABLE_CYCLES - 1);
  localparam logic [T_CNT_WIDTH-1:0] MIN_P  = T_CNT_WIDTH'(MIN_PERIOD);
  localparam logic [T_CNT_WIDTH-1:0] MAX_P  = T_CNT_WIDTH'(MAX_PERIOD);

  stb_ctrl_state_t        state;
  logic [SC_W-1:0]        stable_cnt;
  logic [SC_W-1:0]        stable_nxt;
  logic [T_CNT_WIDTH-1:0] last_period;
  logic                   same;
  logic                   stable_hit;
  logic                   in_range;
  logic                   abort;
  stb_ctrl_status_t       abort_st;
  logic                   tmr_load;
  logic [TMR_WIDTH-1:0]   tmr_val;
  logic                   tmr_en;
  logic                   tmr_zero;

  assign same       = (gen_period_i == last_period);
  assign stable_nxt = (stable_cnt == SC_MAX) ? stable_cnt : stable_cnt + 1'b1;
  assign stable_hit = same && (stable_nxt == SC_MAX);
  assign in_range   = (gen_period_i >= MIN_P) && (gen_period_i <= MAX_P);
  assign tmr_en     = (state == GEN_RST) || (state == ARM) ||
                      (state == WAIT_BUSY) || (state == WAIT_STABLE);

  // One timer serves all three intervals; it is reloaded on each phase change.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE:    if (start_i)  begin tmr_load = 1'b1; tmr_val = TMR_WIDTH'(RST_CYCLES - 1);     end
      GEN_RST: if (tmr_zero) begin tmr_load = 1'b1; tmr_val = TMR_WIDTH'(RUN_HOLD - 1);       end
      ARM:     if (tmr_zero) begin tmr_load = 1'b1; tmr_val = TMR_WIDTH'(TIMEOUT_CYCLES - 1); end
      default: ;
    endcase
  end

  // Exit priority: stop > generator error > timeout > range failure.
  always_comb begin
    abort    = 1'b0;
    abort_st = ST_OK;
    if (state != IDLE) begin
      if (stop_i) begin
        abort = 1'b1;
      end else if (gen_err_i && ((state == WAIT_STABLE) || (state == RUN))) begin
        abort    = 1'b1;
        abort_st = ST_GEN_ERR;
      end else if (tmr_zero && ((state == WAIT_BUSY) || (state == WAIT_STABLE))) begin
        abort    = 1'b1;
        abort_st = ST_TIMEOUT;
      end else if ((state == WAIT_STABLE) && stable_hit && !in_range) begin
        abort    = 1'b1;
        abort_st = ST_RANGE;
      end
    end
  end

  cycle_timer #(.TMR_WIDTH(TMR_WIDTH)) u_timer (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state       <= IDLE;
      gen_rst_o   <= 1'b0;
      gen_run_o   <= 1'b0;
      gen_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
      status_o    <= ST_OK;
      period_o    <= '0;
      stable_cnt  <= '0;
      last_period <= '0;
    end else begin
      done_o <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        gen_rst_o <= 1'b0;
        gen_run_o <= 1'b0;
        gen_oe_o  <= 1'b0;
        busy_o    <= 1'b0;
        running_o <= 1'b0;
        done_o    <= 1'b1;
        status_o  <= abort_st;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            state     <= GEN_RST;
            gen_rst_o <= 1'b1;
            busy_o    <= 1'b1;
            status_o  <= ST_OK;
          end
          GEN_RST: if (tmr_zero) begin
            state     <= ARM;
            gen_rst_o <= 1'b0;
            gen_run_o <= 1'b1;
          end
          ARM: if (tmr_zero) begin
            state     <= WAIT_BUSY;
            gen_run_o <= 1'b0;
          end
          WAIT_BUSY: if (!gen_rdy_i) begin
            state       <= WAIT_STABLE;
            stable_cnt  <= '0;
            last_period <= gen_period_i;
          end
          WAIT_STABLE: begin
            if (!same) begin
              stable_cnt  <= '0;
              last_period <= gen_period_i;
            end else if (stable_hit) begin
              state     <= RUN;
              period_o  <= gen_period_i;
              gen_oe_o  <= 1'b1;
              running_o <= 1'b1;
            end else begin
              stable_cnt <= stable_nxt;
            end
          end
          RUN: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stb_ctrl.sv
// Directed bench for stb_ctrl with a hand-driven generator model.
module tb_stb_ctrl;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        gen_rdy_i = 1'b1;
  logic        gen_err_i = 1'b0;
  logic [31:0] gen_period_i = 32'd0;
  logic        gen_rst_o, gen_run_o, gen_oe_o, busy_o, running_o, done_o;
  logic [1:0]  status_o;
  logic [31:0] period_o;

  int total = 0;
  int bad   = 0;

  stb_ctrl #(.TIMEOUT_CYCLES(200)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .gen_rdy_i    (gen_rdy_i),
    .gen_err_i    (gen_err_i),
    .gen_period_i (gen_period_i),
    .gen_rst_o    (gen_rst_o),
    .gen_run_o    (gen_run_o),
    .gen_oe_o     (gen_oe_o),
    .busy_o       (busy_o),
    .running_o    (running_o),
    .done_o       (done_o),
    .status_o     (status_o),
    .period_o     (period_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Start, wait out reset/arm, then present a constant period until RUN or done.
  task automatic go_run(input logic [31:0] p);
    int n;
    gen_rdy_i = 1'b1;
    start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0;
    while (!gen_run_o && n < 20) begin tick(); n++; end
    while (gen_run_o && n < 40) begin tick(); n++; end
    gen_rdy_i = 1'b0;
    gen_period_i = p;
    while (!running_o && !done_o && n < 80) begin tick(); n++; end
    total++;
    if (n >= 80) begin
      bad++;
      $display("FAIL go_run_bound: cycles=%0d limit=80", n);
    end
  endtask

  task automatic stop_now();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    gen_rdy_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    arst_i = 1'b0;
    tick();
    total++;
    if ({gen_rst_o, gen_run_o, gen_oe_o, busy_o, running_o, done_o, status_o} !== 8'b0) begin
      bad++;
      $display("FAIL reset_outputs: got=%b want=0", {gen_rst_o, gen_run_o, gen_oe_o, busy_o, running_o, done_o, status_o});
    end
    total++;
    if (period_o !== 32'd0) begin bad++; $display("FAIL reset_period: got=%0d want=0", period_o); end
  endtask

  task automatic test_basic();
    int n;
    start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0;
    while (gen_rst_o && n < 20) begin n++; tick(); end
    total++;
    if (n !== 4) begin bad++; $display("FAIL rst_len: got=%0d want=4", n); end
    n = 0;
    while (gen_run_o && n < 20) begin n++; tick(); end
    total++;
    if (n !== 4) begin bad++; $display("FAIL run_len: got=%0d want=4", n); end
    gen_rdy_i = 1'b0;
    for (int i = 0; i < 50; i++) begin gen_period_i = 32'd600 + 32'(i); tick(); end
    total++;
    if (running_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL unstable_hold: running=%b busy=%b want 0/1", running_o, busy_o);
    end
    gen_period_i = 32'd1000;
    n = 0;
    while (!running_o && n < 40) begin n++; tick(); end
    total++;
    if (running_o !== 1'b1 || gen_oe_o !== 1'b1 || status_o !== 2'd0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL basic_run: run=%b oe=%b st=%0d busy=%b want 1/1/0/1", running_o, gen_oe_o, status_o, busy_o);
    end
    total++;
    if (period_o !== 32'd1000) begin bad++; $display("FAIL basic_period: got=%0d want=1000", period_o); end
  endtask

  task automatic test_stop_err();
    stop_i = 1'b1; gen_err_i = 1'b1; tick(); stop_i = 1'b0; gen_err_i = 1'b0;
    total++;
    if (status_o !== 2'd0 || done_o !== 1'b1 || gen_oe_o !== 1'b0 || busy_o !== 1'b0 || running_o !== 1'b0) begin
      bad++; $display("FAIL stop_err: st=%0d done=%b oe=%b busy=%b run=%b want 0/1/0/0/0", status_o, done_o, gen_oe_o, busy_o, running_o);
    end
    tick();
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL done_width: got=%b want=0", done_o); end
    gen_rdy_i = 1'b1;
  endtask

  task automatic test_range();
    go_run(32'd8);
    total++;
    if (done_o !== 1'b1 || status_o !== 2'd2 || period_o !== 32'd1000 || gen_oe_o !== 1'b0) begin
      bad++; $display("FAIL range_low8: done=%b st=%0d per=%0d oe=%b want 1/2/1000/0", done_o, status_o, period_o, gen_oe_o);
    end
    tick(); gen_rdy_i = 1'b1;
    go_run(32'd15);
    total++;
    if (status_o !== 2'd2 || running_o !== 1'b0) begin
      bad++; $display("FAIL range_15: st=%0d run=%b want 2/0", status_o, running_o);
    end
    tick();
    go_run(32'd16);
    total++;
    if (running_o !== 1'b1 || period_o !== 32'd16) begin
      bad++; $display("FAIL range_min: run=%b per=%0d want 1/16", running_o, period_o);
    end
    stop_now();
    go_run(32'd1073741824);
    total++;
    if (running_o !== 1'b1 || period_o !== 32'd1073741824) begin
      bad++; $display("FAIL range_max: run=%b per=%0d want 1/1073741824", running_o, period_o);
    end
    stop_now();
    go_run(32'd1073741825);
    total++;
    if (status_o !== 2'd2 || period_o !== 32'd1073741824) begin
      bad++; $display("FAIL range_over: st=%0d per=%0d want 2/1073741824", status_o, period_o);
    end
    tick(); gen_rdy_i = 1'b1;
  endtask

  task automatic test_gen_err();
    go_run(32'd1000);
    gen_err_i = 1'b1; tick(); gen_err_i = 1'b0;
    total++;
    if (gen_oe_o !== 1'b0 || status_o !== 2'd3 || done_o !== 1'b1) begin
      bad++; $display("FAIL gen_err: oe=%b st=%0d done=%b want 0/3/1", gen_oe_o, status_o, done_o);
    end
    gen_rdy_i = 1'b1;
    tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    total++;
    if (status_o !== 2'd0 || busy_o !== 1'b1 || gen_rst_o !== 1'b1) begin
      bad++; $display("FAIL restart_status: st=%0d busy=%b rst=%b want 0/1/1", status_o, busy_o, gen_rst_o);
    end
    stop_now();
  endtask

  task automatic test_timeout();
    int n;
    start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0;
    while (!gen_run_o && n < 20) begin tick(); n++; end
    while (gen_run_o && n < 40) begin tick(); n++; end
    gen_rdy_i = 1'b0;
    n = 0;
    while (!done_o && n < 400) begin
      gen_period_i = ((n / 5) % 2 == 0) ? 32'd1000 : 32'd1001;
      tick(); n++;
    end
    total++;
    if (n !== 200) begin bad++; $display("FAIL timeout_len: got=%0d want=200", n); end
    total++;
    if (status_o !== 2'd1 || gen_oe_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL timeout_status: st=%0d oe=%b busy=%b want 1/0/0", status_o, gen_oe_o, busy_o);
    end
    tick();
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL timeout_done_width: got=%b want=0", done_o); end
    gen_rdy_i = 1'b1;
  endtask

  task automatic test_start_ignored();
    int n;
    start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
    total++;
    if (gen_rst_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL start_stop_idle: rst=%b busy=%b done=%b want 1/1/0", gen_rst_o, busy_o, done_o);
    end
    n = 0;
    while (!gen_run_o && n < 20) begin tick(); n++; end
    while (gen_run_o && n < 40) begin tick(); n++; end
    gen_rdy_i = 1'b0;
    gen_period_i = 32'd300; tick();
    gen_period_i = 32'd301; tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    total++;
    if (gen_rst_o !== 1'b0 || gen_run_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL start_in_wait: rst=%b runh=%b busy=%b done=%b want 0/0/1/0", gen_rst_o, gen_run_o, busy_o, done_o);
    end
    stop_now();
  endtask

  task automatic test_async_reset();
    int n;
    int dones;
    start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0;
    while (!gen_run_o && n < 20) begin tick(); n++; end
    #2 arst_i = 1'b1;
    #1;
    total++;
    if ({gen_rst_o, gen_run_o, gen_oe_o, busy_o, running_o, done_o, status_o} !== 8'b0 || period_o !== 32'd0) begin
      bad++; $display("FAIL async_reset: outs=%b per=%0d want 0/0", {gen_rst_o, gen_run_o, gen_oe_o, busy_o, running_o, done_o, status_o}, period_o);
    end
    tick(); arst_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (done_o) dones++; end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL reset_no_done: got=%0d want=0", dones); end
    go_run(32'd1000);
    total++;
    if (running_o !== 1'b1 || period_o !== 32'd1000 || status_o !== 2'd0) begin
      bad++; $display("FAIL post_reset_run: run=%b per=%0d st=%0d want 1/1000/0", running_o, period_o, status_o);
    end
    stop_now();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop_err();
    test_range();
    test_gen_err();
    test_timeout();
    test_start_ignored();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
